// File: rtl/zoom_nni_varredura_if.sv
// Handshake and result bus of the nearest-neighbour raster scanner.
// Controller side (master) drives the commands and saida_pronta. The
// scanner side (slave) drives the pixel stream and status.
interface zoom_nni_varredura_if #(
    parameter int COORD_W = 10,
    parameter int ADDR_W  = 19
);
    logic               iniciar;
    logic               cancelar;
    logic               modo_zoom;
    logic [1:0]         fator_zoom;
    logic               saida_pronta;
    logic               saida_valida;
    logic [COORD_W-1:0] x_destino;
    logic [COORD_W-1:0] y_destino;
    logic [COORD_W-1:0] x_fonte;
    logic [COORD_W-1:0] y_fonte;
    logic [ADDR_W-1:0]  endereco_fonte;
    logic [ADDR_W-1:0]  endereco_destino;
    logic [COORD_W-1:0] largura_dest;
    logic [COORD_W-1:0] altura_dest;
    logic               ocupado;
    logic               concluido;
    logic [1:0]         estado_dbg;

    modport master (
        output iniciar, cancelar, modo_zoom, fator_zoom, saida_pronta,
        input  saida_valida, x_destino, y_destino, x_fonte, y_fonte,
               endereco_fonte, endereco_destino, largura_dest, altura_dest,
               ocupado, concluido, estado_dbg
    );

    modport slave (
        input  iniciar, cancelar, modo_zoom, fator_zoom, saida_pronta,
        output saida_valida, x_destino, y_destino, x_fonte, y_fonte,
               endereco_fonte, endereco_destino, largura_dest, altura_dest,
               ocupado, concluido, estado_dbg
    );
endinterface

// File: rtl/zoom_nni_varredura.sv
// Raster scanner for nearest-neighbour zoom. Walks the destination frame
// in raster order and presents, per pixel, the destination coordinates,
// the mapped source coordinates and both linear addresses.
//
// Handshake: a pixel transfers on a rising edge where saida_valida and
// saida_pronta are both 1. saida_valida never depends on saida_pronta,
// and every pixel output stays stable until the pixel transfers.
// cancelar wins over a transfer in the same cycle.
module zoom_nni_varredura #(
    parameter int LARGURA_FONTE = 160,
    parameter int ALTURA_FONTE  = 120,
    parameter int LARGURA_MAX   = 640,
    parameter int ALTURA_MAX    = 480,
    parameter int COORD_W       = 10,
    parameter int ADDR_W        = 19
) (
    input logic             clk,
    input logic             reset_n,
    zoom_nni_varredura_if.slave bus
);
    // Extra headroom so the enlarged size (up to 8x) can be compared
    // against the clip limit without overflowing.
    localparam int EXT_W = COORD_W + 4;
    localparam logic [ADDR_W-1:0] LF_A = ADDR_W'(LARGURA_FONTE);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        EMITINDO = 2'd1,
        FIM      = 2'd2
    } estado_t;

    estado_t estado, prox_estado;

    logic               modo_r;
    logic [1:0]         k_r;
    logic [COORD_W-1:0] larg_r, alt_r;
    logic [COORD_W-1:0] x_r, y_r;
    logic [ADDR_W-1:0]  base_fonte_r;  // y_fonte * LARGURA_FONTE
    logic [ADDR_W-1:0]  end_dest_r;    // y_destino * largura_dest + x_destino

    logic [EXT_W-1:0]   larg_amp, alt_amp;
    logic [COORD_W-1:0] larg_calc, alt_calc;
    logic               inicio, dim_zero, transf, fim_linha, ultimo;
    logic [COORD_W-1:0] y_prox, mascara;
    logic [3:0]         um_desl;
    logic [ADDR_W-1:0]  incr_base;
    logic [COORD_W-1:0] x_fonte, y_fonte;

    // Destination size for the requested zoom: enlarge and clip, or decimate.
    always_comb begin
        larg_amp = EXT_W'(LARGURA_FONTE) << bus.fator_zoom;
        alt_amp  = EXT_W'(ALTURA_FONTE) << bus.fator_zoom;
        if (bus.modo_zoom) begin
            larg_calc = COORD_W'(LARGURA_FONTE) >> bus.fator_zoom;
            alt_calc  = COORD_W'(ALTURA_FONTE) >> bus.fator_zoom;
        end else begin
            larg_calc = (larg_amp > EXT_W'(LARGURA_MAX)) ? COORD_W'(LARGURA_MAX)
                                                         : larg_amp[COORD_W-1:0];
            alt_calc  = (alt_amp > EXT_W'(ALTURA_MAX)) ? COORD_W'(ALTURA_MAX)
                                                       : alt_amp[COORD_W-1:0];
        end
    end

    // Per-cycle control decisions shared by the FSM and the datapath.
    always_comb begin
        inicio    = (estado == OCIOSO) && bus.iniciar && !bus.cancelar;
        dim_zero  = (larg_calc == '0) || (alt_calc == '0);
        transf    = (estado == EMITINDO) && bus.saida_pronta && !bus.cancelar;
        fim_linha = (x_r == larg_r - COORD_W'(1));
        ultimo    = fim_linha && (y_r == alt_r - COORD_W'(1));
    end

    // Source row base step on a row wrap. Zooming in, the source row only
    // advances when the new destination row is a multiple of 2^k; zooming
    // out it jumps 2^k source rows every time.
    always_comb begin
        y_prox  = y_r + COORD_W'(1);
        um_desl = 4'd1 << k_r;
        mascara = COORD_W'(um_desl - 4'd1);
        if (modo_r) begin
            incr_base = LF_A << k_r;
        end else if ((y_prox & mascara) == '0) begin
            incr_base = LF_A;
        end else begin
            incr_base = '0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado <= OCIOSO;
        end else begin
            estado <= prox_estado;
        end
    end

    // Next state; cancelar returns to idle from anywhere.
    always_comb begin
        prox_estado = estado;
        case (estado)
            OCIOSO:   if (inicio) prox_estado = dim_zero ? FIM : EMITINDO;
            EMITINDO: if (transf && ultimo) prox_estado = FIM;
            FIM:      prox_estado = OCIOSO;
            default:  prox_estado = OCIOSO;
        endcase
        if (bus.cancelar) begin
            prox_estado = OCIOSO;
        end
    end

    // Config latch at start and incremental raster/address counters.
    // The last pixel does not advance the counters, so it stays visible.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            modo_r       <= 1'b0;
            k_r          <= 2'd0;
            larg_r       <= '0;
            alt_r        <= '0;
            x_r          <= '0;
            y_r          <= '0;
            base_fonte_r <= '0;
            end_dest_r   <= '0;
        end else if (inicio) begin
            modo_r       <= bus.modo_zoom;
            k_r          <= bus.fator_zoom;
            larg_r       <= larg_calc;
            alt_r        <= alt_calc;
            x_r          <= '0;
            y_r          <= '0;
            base_fonte_r <= '0;
            end_dest_r   <= '0;
        end else if (transf && !ultimo) begin
            end_dest_r <= end_dest_r + ADDR_W'(1);
            if (fim_linha) begin
                x_r          <= '0;
                y_r          <= y_prox;
                base_fonte_r <= base_fonte_r + incr_base;
            end else begin
                x_r <= x_r + COORD_W'(1);
            end
        end
    end

    // Coordinate mapping is a plain shift of the registered destination.
    always_comb begin
        x_fonte = modo_r ? (x_r << k_r) : (x_r >> k_r);
        y_fonte = modo_r ? (y_r << k_r) : (y_r >> k_r);
    end

    assign bus.saida_valida     = (estado == EMITINDO);
    assign bus.ocupado          = (estado == EMITINDO);
    assign bus.concluido        = (estado == FIM);
    assign bus.x_destino        = x_r;
    assign bus.y_destino        = y_r;
    assign bus.x_fonte          = x_fonte;
    assign bus.y_fonte          = y_fonte;
    assign bus.endereco_fonte   = base_fonte_r + ADDR_W'(x_fonte);
    assign bus.endereco_destino = end_dest_r;
    assign bus.largura_dest     = larg_r;
    assign bus.altura_dest      = alt_r;
    assign bus.estado_dbg       = estado;
endmodule

// File: tb/tb_zoom_nni_varredura.sv
// Bench for the nearest-neighbour raster scanner. Uses a reduced source
// frame (40x30, clip 160x120) so every scan runs to completion quickly
// while keeping the same enlarge/clip/decimate structure.
module tb_zoom_nni_varredura;
    localparam int LF = 40;
    localparam int AF = 30;
    localparam int LM = 160;
    localparam int AM = 120;
    localparam int CW = 10;
    localparam int AW = 15;
    localparam int W  = 4 * CW + 2 * AW;

    typedef struct {
        logic       modo;
        logic [1:0] fator;
        int         larg;
        int         alt;
        int         pct_baixo;
        int         px;
        int         py;
        int         pxf;
        int         pyf;
        int         pef;
        int         ped;
    } vetor_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    zoom_nni_varredura_if #(.COORD_W(CW), .ADDR_W(AW)) bus ();

    zoom_nni_varredura #(
        .LARGURA_FONTE(LF), .ALTURA_FONTE(AF),
        .LARGURA_MAX(LM), .ALTURA_MAX(AM),
        .COORD_W(CW), .ADDR_W(AW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    // ---------------- scoreboard ----------------
    int n_vet = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];
    vetor_t tabela[5];
    vetor_t ident;

    task automatic verifica(input string nome, input longint atual, input longint esperado);
        n_vet++;
        if (atual != esperado) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nome, atual, esperado);
        end
    endtask

    function automatic logic [W-1:0] empacota(input longint x, input longint y,
                                             input longint xf, input longint yf,
                                             input longint ef, input longint ed);
        return {CW'(x), CW'(y), CW'(xf), CW'(yf), AW'(ef), AW'(ed)};
    endfunction

    function automatic logic [W-1:0] saida_atual();
        return {bus.x_destino, bus.y_destino, bus.x_fonte, bus.y_fonte,
                bus.endereco_fonte, bus.endereco_destino};
    endfunction

    // Expected raster sequence, straight from the mapping formulas.
    task automatic carrega_modelo(input vetor_t v);
        int xf, yf;
        exp_q.delete();
        for (int y = 0; y < v.alt; y++) begin
            for (int x = 0; x < v.larg; x++) begin
                xf = v.modo ? (x << v.fator) : (x >> v.fator);
                yf = v.modo ? (y << v.fator) : (y >> v.fator);
                exp_q.push_back(empacota(xf == 0 && 0 ? 0 : x, y, xf, yf,
                                         yf * LF + xf, y * v.larg + x));
            end
        end
    endtask

    task automatic confere_zeros(input string nome);
        verifica({nome, ".valida"}, longint'(bus.saida_valida), 0);
        verifica({nome, ".ocupado"}, longint'(bus.ocupado), 0);
        verifica({nome, ".concluido"}, longint'(bus.concluido), 0);
        verifica({nome, ".x_destino"}, longint'(bus.x_destino), 0);
        verifica({nome, ".y_destino"}, longint'(bus.y_destino), 0);
        verifica({nome, ".x_fonte"}, longint'(bus.x_fonte), 0);
        verifica({nome, ".y_fonte"}, longint'(bus.y_fonte), 0);
        verifica({nome, ".end_fonte"}, longint'(bus.endereco_fonte), 0);
        verifica({nome, ".end_dest"}, longint'(bus.endereco_destino), 0);
        verifica({nome, ".largura"}, longint'(bus.largura_dest), 0);
        verifica({nome, ".altura"}, longint'(bus.altura_dest), 0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic inicia(input logic modo, input logic [1:0] fator);
        @(negedge clk);
        bus.modo_zoom  = modo;
        bus.fator_zoom = fator;
        bus.iniciar    = 1'b1;
        @(negedge clk);
        bus.iniciar    = 1'b0;
        // Changing the config mid-scan must not matter.
        bus.modo_zoom  = ~modo;
        bus.fator_zoom = ~fator;
    endtask

    task automatic roda(input vetor_t v);
        int transf = 0;
        int ciclos = 0;
        int orcamento = v.larg * v.alt * 4 + 100;
        int probe_idx = v.py * v.larg + v.px;
        carrega_modelo(v);
        inicia(v.modo, v.fator);
        verifica("largura_dest", longint'(bus.largura_dest), v.larg);
        verifica("altura_dest", longint'(bus.altura_dest), v.alt);
        verifica("ocupado_ini", longint'(bus.ocupado), 1);
        while (exp_q.size() > 0 && ciclos < orcamento) begin
            bus.saida_pronta = ($urandom_range(99) >= v.pct_baixo);
            if (!bus.saida_valida) begin
                verifica("valida_em_varredura", 0, 1);
            end else begin
                n_vet++;
                if (saida_atual() !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL pixel[%0d]: got %h expected %h", transf, saida_atual(), exp_q[0]);
                end
                if (transf == probe_idx) begin
                    verifica("probe.x_fonte", longint'(bus.x_fonte), v.pxf);
                    verifica("probe.y_fonte", longint'(bus.y_fonte), v.pyf);
                    verifica("probe.end_fonte", longint'(bus.endereco_fonte), v.pef);
                    verifica("probe.end_dest", longint'(bus.endereco_destino), v.ped);
                end
                if (bus.saida_pronta) begin
                    void'(exp_q.pop_front());
                    transf++;
                end
            end
            @(negedge clk);
            ciclos++;
        end
        if (ciclos >= orcamento) begin
            verifica("scan_timeout", ciclos, -1);
        end
        bus.saida_pronta = 1'b0;
        verifica("transfers", transf, v.larg * v.alt);
        verifica("concluido_pulso", longint'(bus.concluido), 1);
        verifica("valida_em_fim", longint'(bus.saida_valida), 0);
        verifica("ocupado_em_fim", longint'(bus.ocupado), 0);
        @(negedge clk);
        verifica("concluido_baixa", longint'(bus.concluido), 0);
        verifica("valida_ocioso", longint'(bus.saida_valida), 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #3_000_000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vet, n_err);
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int conc;
        bus.iniciar      = 1'b0;
        bus.cancelar     = 1'b0;
        bus.modo_zoom    = 1'b0;
        bus.fator_zoom   = 2'd0;
        bus.saida_pronta = 1'b0;

        //            modo  fator larg alt  %low  px   py   pxf pyf  pef   ped
        tabela[0] = '{1'b0, 2'd1,  80,  60,  0,    5,   3,   2,  1,   42,   245};
        tabela[1] = '{1'b0, 2'd3, 160, 120,  0,  159, 119,  19, 14,  579, 19199};
        tabela[2] = '{1'b1, 2'd2,  10,   7,  0,    1,   1,   4,  4,  164,    11};
        tabela[3] = '{1'b1, 2'd3,   5,   3,  0,    4,   2,  32, 16,  672,    14};
        tabela[4] = '{1'b1, 2'd1,  20,  15, 30,    3,   2,   6,  4,  166,    43};
        ident     = '{1'b0, 2'd0,  40,  30,  0,   39,  29,  39, 29, 1199,  1199};

        #1;
        confere_zeros("reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // cancelar together with iniciar in idle: nothing starts.
        @(negedge clk);
        bus.iniciar  = 1'b1;
        bus.cancelar = 1'b1;
        @(negedge clk);
        bus.iniciar  = 1'b0;
        bus.cancelar = 1'b0;
        verifica("cancel_prio.valida", longint'(bus.saida_valida), 0);
        verifica("cancel_prio.largura", longint'(bus.largura_dest), 0);

        for (int i = 0; i < 5; i++) begin
            roda(tabela[i]);
        end

        // Cancel at pixel 100 of an 80x60 scan: (20,1) stays on the outputs.
        inicia(1'b0, 2'd1);
        bus.saida_pronta = 1'b1;
        repeat (100) @(negedge clk);
        verifica("cancel.x_antes", longint'(bus.x_destino), 20);
        verifica("cancel.y_antes", longint'(bus.y_destino), 1);
        bus.cancelar = 1'b1;
        @(negedge clk);
        bus.cancelar = 1'b0;
        bus.saida_pronta = 1'b0;
        verifica("cancel.valida", longint'(bus.saida_valida), 0);
        verifica("cancel.ocupado", longint'(bus.ocupado), 0);
        verifica("cancel.x_hold", longint'(bus.x_destino), 20);
        verifica("cancel.y_hold", longint'(bus.y_destino), 1);
        conc = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.concluido) conc++;
            @(negedge clk);
        end
        verifica("cancel.sem_concluido", conc, 0);
        roda(ident);

        // Asynchronous reset between edges in the middle of a scan.
        inicia(1'b0, 2'd1);
        bus.saida_pronta = 1'b1;
        repeat (50) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        confere_zeros("reset_async");
        bus.iniciar = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        verifica("reset_iniciar.valida", longint'(bus.saida_valida), 0);
        verifica("reset_iniciar.largura", longint'(bus.largura_dest), 0);
        bus.iniciar = 1'b0;
        bus.saida_pronta = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        verifica("pos_reset.valida", longint'(bus.saida_valida), 0);
        roda(tabela[3]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vet, n_err);
        $finish;
    end
endmodule
